// File: rtl/tournament_branch_predictor.sv
// ---------------------------------------------------------------------------
// tournament_branch_predictor
//
// Tournament direction predictor: a per-PC local-history predictor and a
// gshare global predictor, arbitrated by a per-PC chooser.
//
// - The IF prediction is produced combinationally from the current table state.
// - The indices and predictions used at IF are captured in an IF/ID snapshot.
//   Training strobes issued when the branch resolves in ID therefore update
//   exactly the entries that produced the prediction.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_pc                     PC being fetched
//   if_id_load / if_id_flush  IF/ID snapshot load / flush (flush wins)
//   id_br_en                  resolved branch direction in ID
//   ghr_load, bht_load        shift id_br_en into GHR / local history
//   increment_pht             strengthen taken on local and global PHT entries
//   decrement_pht             strengthen not-taken on the same entries
//   increment_tournament_pht  move the chooser toward global
//   decrement_tournament_pht  move the chooser toward local
//   if_br_pr                  IF chosen prediction (combinational)
//   id_local_pr               snapshotted local prediction
//   id_global_pr              snapshotted global prediction
//   id_br_pr                  snapshotted chosen prediction
// ---------------------------------------------------------------------------
module tournament_branch_predictor #(
    parameter int GHR_WIDTH    = 8,
    parameter int BHT_IDX_BITS = 6,
    parameter int LHR_WIDTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        if_id_load,
    input  logic        if_id_flush,
    input  logic        id_br_en,
    input  logic        ghr_load,
    input  logic        bht_load,
    input  logic        increment_pht,
    input  logic        decrement_pht,
    input  logic        increment_tournament_pht,
    input  logic        decrement_tournament_pht,
    output logic        if_br_pr,
    output logic        id_local_pr,
    output logic        id_global_pr,
    output logic        id_br_pr
);
    localparam int GPHT_ENTRIES = 1 << GHR_WIDTH;
    localparam int BHT_ENTRIES  = 1 << BHT_IDX_BITS;
    localparam int LPHT_ENTRIES = 1 << LHR_WIDTH;

    logic [GHR_WIDTH-1:0] ghr;
    logic [LHR_WIDTH-1:0] bht     [BHT_ENTRIES];
    logic [1:0]           lpht    [LPHT_ENTRIES];
    logic [1:0]           gpht    [GPHT_ENTRIES];
    logic [1:0]           chooser [GPHT_ENTRIES];

    // IF-side lookup
    logic [BHT_IDX_BITS-1:0] if_lidx;
    logic [LHR_WIDTH-1:0]    if_lhist;
    logic [GHR_WIDTH-1:0]    if_gidx;
    logic [GHR_WIDTH-1:0]    if_cidx;
    logic                    if_local_pr;
    logic                    if_global_pr;

    // IF/ID snapshot
    logic                    snap_valid;
    logic [BHT_IDX_BITS-1:0] snap_lidx;
    logic [LHR_WIDTH-1:0]    snap_lhist;
    logic [GHR_WIDTH-1:0]    snap_gidx;
    logic [GHR_WIDTH-1:0]    snap_cidx;
    logic                    snap_local_pr;
    logic                    snap_global_pr;
    logic                    snap_chosen_pr;

    // PC bits that no index uses
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:GHR_WIDTH+2], if_pc[1:0]};

    assign if_lidx      = if_pc[BHT_IDX_BITS+1:2];
    assign if_lhist     = bht[if_lidx];
    assign if_local_pr  = lpht[if_lhist][1];
    assign if_cidx      = if_pc[GHR_WIDTH+1:2];
    assign if_gidx      = if_cidx ^ ghr;
    assign if_global_pr = gpht[if_gidx][1];
    assign if_br_pr     = chooser[if_cidx][1] ? if_global_pr : if_local_pr;

    assign id_local_pr  = snap_local_pr;
    assign id_global_pr = snap_global_pr;
    assign id_br_pr     = snap_chosen_pr;

    // 2-bit saturating counter step; opposing strobes cancel.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt,
                                            input logic inc,
                                            input logic dec);
        logic [1:0] nxt;
        nxt = cnt;
        if (inc && !dec && cnt != 2'b11) nxt = cnt + 2'd1;
        if (dec && !inc && cnt != 2'b00) nxt = cnt - 2'd1;
        return nxt;
    endfunction

    // Table training. It is indexed only by the snapshot and gated by its valid bit.
    // An IF lookup in the same cycle sees the pre-update state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++)  bht[i]  <= '0;
            for (int i = 0; i < LPHT_ENTRIES; i++) lpht[i] <= 2'b01;
            for (int i = 0; i < GPHT_ENTRIES; i++) begin
                gpht[i]    <= 2'b01;
                chooser[i] <= 2'b01;
            end
        end else if (snap_valid) begin
            if (ghr_load)
                ghr <= {ghr[GHR_WIDTH-2:0], id_br_en};
            if (bht_load)
                bht[snap_lidx] <= {bht[snap_lidx][LHR_WIDTH-2:0], id_br_en};
            lpht[snap_lhist]   <= sat_step(lpht[snap_lhist], increment_pht, decrement_pht);
            gpht[snap_gidx]    <= sat_step(gpht[snap_gidx], increment_pht, decrement_pht);
            chooser[snap_cidx] <= sat_step(chooser[snap_cidx],
                                           increment_tournament_pht,
                                           decrement_tournament_pht);
        end
    end

    // IF/ID snapshot. Flush has priority over load.
    // A flush clears the whole entry, so a flushed slot can never train.
    always_ff @(posedge clk) begin
        if (rst || if_id_flush) begin
            snap_valid     <= 1'b0;
            snap_lidx      <= '0;
            snap_lhist     <= '0;
            snap_gidx      <= '0;
            snap_cidx      <= '0;
            snap_local_pr  <= 1'b0;
            snap_global_pr <= 1'b0;
            snap_chosen_pr <= 1'b0;
        end else if (if_id_load) begin
            snap_valid     <= 1'b1;
            snap_lidx      <= if_lidx;
            snap_lhist     <= if_lhist;
            snap_gidx      <= if_gidx;
            snap_cidx      <= if_cidx;
            snap_local_pr  <= if_local_pr;
            snap_global_pr <= if_global_pr;
            snap_chosen_pr <= if_br_pr;
        end
    end

endmodule

// File: doc/tournament_branch_predictor.md
Name: tournament_branch_predictor

Overview:
- Direction predictor that feeds the stall/control logic.
- Produces the IF-stage taken prediction and the ID-stage local, global and chosen predictions.
- Consumes the ghr/bht/pht/tournament update strobes issued when a branch resolves in ID.
- Combines a per-PC local-history predictor, a gshare global predictor and a per-PC chooser. Prediction indices are snapshotted at IF so training hits exactly the entries used to predict.

Parameters:
- GHR_WIDTH, 8, global history bits; gshare PHT and chooser each have 2^GHR_WIDTH entries.
- BHT_IDX_BITS, 6, local history table index bits (2^BHT_IDX_BITS entries).
- LHR_WIDTH, 8, bits per local history; local PHT has 2^LHR_WIDTH entries.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_pc  in  32  PC being fetched
- if_id_load  in  1  IF/ID register load enable
- if_id_flush  in  1  IF/ID register flush
- id_br_en  in  1  resolved direction of branch in ID
- ghr_load  in  1  shift id_br_en into GHR
- bht_load  in  1  shift id_br_en into local history at snapshotted index
- increment_pht  in  1  strengthen-taken on local and global PHT entries
- decrement_pht  in  1  strengthen-not-taken on both
- increment_tournament_pht  in  1  move chooser toward global
- decrement_tournament_pht  in  1  move chooser toward local
- if_br_pr  out  1  IF chosen prediction (combinational)
- id_local_pr  out  1  snapshotted local prediction
- id_global_pr  out  1  snapshotted global prediction
- id_br_pr  out  1  snapshotted chosen prediction

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Counters: 2-bit saturating. Taken when MSB=1. Reset value 2'b01. Chooser MSB=1 selects global.
- IF indexing, all combinational from current table state:
  - lidx = if_pc[BHT_IDX_BITS+1:2]
  - lhist = BHT[lidx]
  - local_pr = LPHT[lhist].MSB
  - gidx = if_pc[GHR_WIDTH+1:2] XOR GHR
  - global_pr = GPHT[gidx].MSB
  - cidx = if_pc[GHR_WIDTH+1:2]
  - if_br_pr = CHOOSER[cidx].MSB ? global_pr : local_pr
- Snapshot register (ID side): fields valid, lidx, lhist, gidx, cidx, local_pr, global_pr, chosen_pr.
  - rst: all zero.
  - Else if_id_flush: valid=0, preds=0. Flush has priority over load.
  - Else if_id_load: capture IF values, valid=1.
  - Else: hold.
  - id_* outputs are the snapshot fields, so they are 0 after reset.
- Updates occur on the clock edge, use snapshot indices only, and apply only when snapshot valid=1:
  - ghr_load: GHR <= {GHR[GHR_WIDTH-2:0], id_br_en}.
  - bht_load: BHT[snap.lidx] <= {old[LHR_WIDTH-2:0], id_br_en}.
  - increment_pht: LPHT[snap.lhist] and GPHT[snap.gidx] +1, saturating at 3.
  - decrement_pht: the same entries -1, saturating at 0.
  - Chooser update at CHOOSER[snap.cidx], same saturation rules.
- Simultaneous increment and decrement of the same table: no change.
- No read-after-write bypass: an IF lookup in the same cycle as an update sees pre-update values.
- Updates and snapshot capture in the same edge are independent.
- rst mid-operation: GHR=0, every BHT entry=0, every PHT and chooser entry=2'b01, snapshot cleared. All pending strobes in that cycle are ignored.
- Stall (if_id_load=0): snapshot holds, and strobes still apply to the held indices. The upstream control logic gates the strobes with the IF/ID load, so no double training occurs.

Test Plan:
- Reset, then if_pc=0x60: if_br_pr=0. After one load cycle, id_local_pr=id_global_pr=id_br_pr=0. GHR=0.
- Load with if_pc=0x40, then assert increment_pht with ghr_load=bht_load=1, id_br_en=1. Result: LPHT[0]=2'b10, GPHT[0x10]=2'b10, GHR=0x01, BHT[0x10]=0x01.
- Drive increment_pht for 4 cycles on a held snapshot: counter saturates at 3. Drive decrement_pht for 5 cycles: counter reaches 0 and stays there.
- Drive increment_tournament_pht once on cidx=0x10 (chooser becomes 2'b10), preload GPHT[gidx]=3 and LPHT=0. Fetch if_pc=0x40: if_br_pr=1 (global chosen). Decrement twice: if_br_pr=0.
- Assert if_id_flush and if_id_load together with a taken-predicting PC: id_br_pr=0 next cycle. Then assert increment_pht: no table changes because valid=0.
- Assert increment_pht and decrement_pht in the same cycle: no entry changes. Assert rst while strobes are active: all tables return to reset values.
